// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   Write-back queue in front of the single regfile write port. Results from
//   the load unit and the ALU are buffered in arrival order (load before ALU
//   when both arrive together) and retired one per cycle unless stall_i
//   holds the head. Valid queued values are forwarded to the two decode read
//   ports, with the youngest matching entry winning.
//
// Ports
//   clk, rst                  core clock (rising edge), async active-high reset
//   stall_i                   suppress the regfile write this cycle, hold head
//   ld_valid/ld_ready         load result handshake, ld_rd / ld_data payload
//   alu_valid/alu_ready       ALU result handshake, alu_rd / alu_data payload
//   wr_en/wr_addr/wr_data     regfile write port, driven from the head entry
//   r1_addr, r2_addr          decode read addresses
//   fwd1_hit/fwd1_data        forwarding result for r1_addr
//   fwd2_hit/fwd2_data        forwarding result for r2_addr
//   count                     number of occupied entries
module regfile_wb_queue #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_i,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [AW-1:0]              ld_rd,
  input  logic [XLEN-1:0]            ld_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AW-1:0]              alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_addr,
  output logic [XLEN-1:0]            wr_data,
  input  logic [AW-1:0]              r1_addr,
  input  logic [AW-1:0]              r2_addr,
  output logic                       fwd1_hit,
  output logic [XLEN-1:0]            fwd1_data,
  output logic                       fwd2_hit,
  output logic [XLEN-1:0]            fwd2_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    q_rd    [DEPTH];
  logic [XLEN-1:0]  q_data  [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  logic             ld_take;
  logic             alu_take;
  logic             deq;
  logic [PW-1:0]    alu_slot;
  logic [PW-1:0]    age_idx [DEPTH];

  // Readiness looks only at the current occupancy: a slot freed by a
  // same-cycle dequeue is not handed out. A load with rd == 0 completes its
  // handshake but takes no slot, so it does not reduce room for the ALU.
  always_comb begin
    ld_ready  = count < CW'(DEPTH);
    ld_take   = ld_valid && ld_ready && (ld_rd != '0);
    alu_ready = (count + CW'(ld_take)) < CW'(DEPTH);
    alu_take  = alu_valid && alu_ready && (alu_rd != '0);
    deq       = wr_en && !stall_i;
    alu_slot  = tail + PW'(ld_take);
  end

  assign wr_en   = (count != '0);
  assign wr_addr = q_rd[head];
  assign wr_data = q_data[head];

  // Entry storage and pointers. Entry contents are cleared on reset so the
  // write port reads as zero while rst is held. Enqueue slots can never
  // coincide with the head being retired because ready excludes a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (deq) begin
        q_valid[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (ld_take) begin
        q_rd[tail]    <= ld_rd;
        q_data[tail]  <= ld_data;
        q_valid[tail] <= 1'b1;
      end
      if (alu_take) begin
        q_rd[alu_slot]    <= alu_rd;
        q_data[alu_slot]  <= alu_data;
        q_valid[alu_slot] <= 1'b1;
      end
      tail  <= tail + PW'(ld_take) + PW'(alu_take);
      count <= count + CW'(ld_take) + CW'(alu_take) - CW'(deq);
    end
  end

  // Entries listed oldest first, starting at the head.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_idx[i] = head + PW'(i);
    end
  end

  // Scan oldest to youngest so a later match overrides an earlier one and the
  // youngest queued value for the address is forwarded.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[age_idx[i]] && (r1_addr != '0) && (q_rd[age_idx[i]] == r1_addr)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = q_data[age_idx[i]];
      end
      if (q_valid[age_idx[i]] && (r2_addr != '0) && (q_rd[age_idx[i]] == r2_addr)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = q_data[age_idx[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue
//   Directed bench for regfile_wb_queue. Accepted results are pushed to a
//   scoreboard queue when driven; each retired write is compared against the
//   scoreboard head and popped.
module tb_regfile_wb_queue;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_i;
  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   r1_addr;
  logic [AW-1:0]   r2_addr;
  logic            fwd1_hit;
  logic [XLEN-1:0] fwd1_data;
  logic            fwd2_hit;
  logic [XLEN-1:0] fwd2_data;
  logic [2:0]      count;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  regfile_wb_queue #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (stall_i),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .r1_addr   (r1_addr),
    .r2_addr   (r2_addr),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [AW-1:0] lrd,
                               input logic [XLEN-1:0] ldat, input logic av,
                               input logic [AW-1:0] ard, input logic [XLEN-1:0] adat,
                               input logic st);
    ld_valid  = lv;
    ld_rd     = lrd;
    ld_data   = ldat;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = adat;
    stall_i   = st;
  endtask

  // Check the current outputs against the scoreboard, clock one edge and
  // apply the transfers the handshake rules allow to the scoreboard.
  task automatic step(input string tag);
    int  cnt;
    logic ldr, ldt, alr, alut, deq;
    wb_t ld_e, alu_e;
    cnt   = sb.size();
    ldr   = cnt < DEPTH;
    ldt   = ld_valid && ldr && (ld_rd != '0);
    alr   = (cnt + int'(ldt)) < DEPTH;
    alut  = alu_valid && alr && (alu_rd != '0);
    deq   = (cnt != 0) && !stall_i;
    ld_e  = '{rd: ld_rd, data: ld_data};
    alu_e = '{rd: alu_rd, data: alu_data};
    checkOutput({tag, ":count"}, 64'(count), 64'(cnt));
    checkOutput({tag, ":wr_en"}, 64'(wr_en), 64'(cnt != 0));
    checkOutput({tag, ":ld_ready"}, 64'(ld_ready), 64'(ldr));
    checkOutput({tag, ":alu_ready"}, 64'(alu_ready), 64'(alr));
    if (cnt != 0) begin
      checkOutput({tag, ":wr_addr"}, 64'(wr_addr), 64'(sb[0].rd));
      checkOutput({tag, ":wr_data"}, 64'(wr_data), 64'(sb[0].data));
    end
    @(posedge clk);
    #1;
    if (deq) void'(sb.pop_front());
    if (ldt) sb.push_back(ld_e);
    if (alut) sb.push_back(alu_e);
  endtask

  task automatic idle(input logic st);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, st);
  endtask

  task automatic drain(input string tag);
    idle(1'b0);
    for (int k = 0; k < 2 * DEPTH && sb.size() != 0; k++) step(tag);
    checkOutput({tag, ":drained_count"}, 64'(count), 64'(0));
    checkOutput({tag, ":drained_wr_en"}, 64'(wr_en), 64'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    r1_addr = 5'd5;
    r2_addr = 5'd0;
    idle(1'b0);
    #1;
    checkOutput("rst:wr_en", 64'(wr_en), 64'(0));
    checkOutput("rst:wr_addr", 64'(wr_addr), 64'(0));
    checkOutput("rst:wr_data", 64'(wr_data), 64'(0));
    checkOutput("rst:count", 64'(count), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset
    checkOutput("t1:ld_ready", 64'(ld_ready), 64'(1));
    checkOutput("t1:alu_ready", 64'(alu_ready), 64'(1));
    checkOutput("t1:fwd1_hit", 64'(fwd1_hit), 64'(0));
    step("t1_idle");

    // Single ALU result, written on the following cycle
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    step("t2_enq");
    idle(1'b0);
    checkOutput("t2:wr_en", 64'(wr_en), 64'(1));
    checkOutput("t2:wr_addr", 64'(wr_addr), 64'(7));
    checkOutput("t2:wr_data", 64'(wr_data), 64'(32'hDEADBEEF));
    step("t2_wr");
    checkOutput("t2:wr_en_after", 64'(wr_en), 64'(0));

    // Load and ALU together: load retires first
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0);
    step("t3_enq");
    idle(1'b0);
    checkOutput("t3:count2", 64'(count), 64'(2));
    checkOutput("t3:first_addr", 64'(wr_addr), 64'(3));
    step("t3_wr1");
    checkOutput("t3:count1", 64'(count), 64'(1));
    checkOutput("t3:second_addr", 64'(wr_addr), 64'(4));
    checkOutput("t3:second_data", 64'(wr_data), 64'(32'h22));
    step("t3_wr2");
    checkOutput("t3:count0", 64'(count), 64'(0));

    // Fill under stall; tail wraps past the end of the buffer
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, AW'(10 + i), 32'h100 + i, 1'b1);
      step("t4_fill");
    end
    idle(1'b1);
    checkOutput("t4:count_full", 64'(count), 64'(4));
    checkOutput("t4:ld_ready_full", 64'(ld_ready), 64'(0));
    checkOutput("t4:alu_ready_full", 64'(alu_ready), 64'(0));
    checkOutput("t4:head_held", 64'(wr_addr), 64'(10));
    applyStimulus(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h210, 1'b1);
    step("t4_full_push");
    checkOutput("t4:count_still_full", 64'(count), 64'(4));
    checkOutput("t4:head_still_held", 64'(wr_data), 64'(32'h100));
    drain("t4_drain");

    // Forwarding picks the youngest match
    r1_addr = 5'd9;
    r2_addr = 5'd0;
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'hA, 1'b1);
    checkOutput("t5:not_yet_visible", 64'(fwd1_hit), 64'(0));
    step("t5_enq_a");
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'hB, 1'b1);
    checkOutput("t5:hit_a", 64'(fwd1_hit), 64'(1));
    checkOutput("t5:data_a", 64'(fwd1_data), 64'(32'hA));
    step("t5_enq_b");
    idle(1'b1);
    checkOutput("t5:hit_b", 64'(fwd1_hit), 64'(1));
    checkOutput("t5:data_b", 64'(fwd1_data), 64'(32'hB));
    checkOutput("t5:r2_zero_hit", 64'(fwd2_hit), 64'(0));
    checkOutput("t5:r2_zero_data", 64'(fwd2_data), 64'(0));
    r2_addr = 5'd9;
    #1;
    checkOutput("t5:r2_hit", 64'(fwd2_hit), 64'(1));
    checkOutput("t5:r2_data", 64'(fwd2_data), 64'(32'hB));
    r2_addr = 5'd0;
    drain("t5_drain");
    checkOutput("t5:hit_after_drain", 64'(fwd1_hit), 64'(0));

    // rd == 0 is accepted but not queued
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h55, 1'b0);
    checkOutput("t6:alu_ready_rd0", 64'(alu_ready), 64'(1));
    step("t6_rd0");
    idle(1'b0);
    checkOutput("t6:count_rd0", 64'(count), 64'(0));

    // Mid-operation reset discards queued entries
    r1_addr = 5'd1;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, AW'(i), 32'h300 + i, 1'b0, '0, '0, 1'b1);
      step("t6_fill");
    end
    idle(1'b1);
    checkOutput("t6:count3", 64'(count), 64'(3));
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    checkOutput("t6:rst_wr_en", 64'(wr_en), 64'(0));
    checkOutput("t6:rst_count", 64'(count), 64'(0));
    checkOutput("t6:rst_wr_addr", 64'(wr_addr), 64'(0));
    checkOutput("t6:rst_wr_data", 64'(wr_data), 64'(0));
    checkOutput("t6:rst_fwd1_hit", 64'(fwd1_hit), 64'(0));
    checkOutput("t6:rst_fwd1_data", 64'(fwd1_data), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1'b0);
    step("t6_post_rst");

    // Normal operation resumes after reset
    applyStimulus(1'b1, 5'd12, 32'hC0FFEE, 1'b0, '0, '0, 1'b0);
    step("t6_resume");
    drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
